// File: rtl/mem_arbiter_2to1_if.sv
// Bus bundle between the two L1 cache memory ports, the arbiter and the
// off-chip memory. The arbiter attaches through the slave modport: it
// serves the cache clients and drives the memory side. The surrounding
// caches and memory model attach through the master modport.
interface mem_arbiter_2to1_if #(
   parameter int AW = 30,
   parameter int DW = 32
);
   // Client I (instruction cache)
   logic          i_read;
   logic          i_write;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_wdata;
   logic [DW-1:0] i_rdata;
   logic          i_ready;

   // Client D (data cache)
   logic          d_read;
   logic          d_write;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ready;

   // Shared memory port
   logic          mem_read;
   logic          mem_write;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   modport slave (
      input  i_read, i_write, i_addr, i_wdata,
      output i_rdata, i_ready,
      input  d_read, d_write, d_addr, d_wdata,
      output d_rdata, d_ready,
      output mem_read, mem_write, mem_addr, mem_wdata,
      input  mem_rdata, mem_ready
   );

   modport master (
      output i_read, i_write, i_addr, i_wdata,
      input  i_rdata, i_ready,
      output d_read, d_write, d_addr, d_wdata,
      input  d_rdata, d_ready,
      input  mem_read, mem_write, mem_addr, mem_wdata,
      output mem_rdata, mem_ready
   );
endinterface

// File: rtl/mem_arbiter_2to1.sv
// Two-client memory arbiter: shares one off-chip memory port between the
// L1 instruction cache (client I) and the L1 data cache (client D).
// One transaction is in flight at a time; memory-side outputs are registered.
// Flow: IDLE (arbitrate, latch request) -> BUSY (wait mem_ready) -> RESP
// (one-cycle ready pulse to the winner) -> IDLE.
// Optional macro MEM_ARB_DPRIO_EN: when defined, client D always wins a
// simultaneous request (fixed priority); otherwise round-robin is used and
// D wins the first tie after reset.
module mem_arbiter_2to1 #(
   parameter int AW = 30,
   parameter int DW = 32
) (
   input logic                clk,
   input logic                proc_reset_n,
   mem_arbiter_2to1_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_e;

   typedef enum logic {
      CLIENT_I = 1'b0,
      CLIENT_D = 1'b1
   } client_e;

   state_e        state_q, state_d;
   client_e       owner_q, owner_d;
`ifndef MEM_ARB_DPRIO_EN
   client_e       lastGrant_q, lastGrant_d;
`endif
   logic          memRead_q, memRead_d;
   logic          memWrite_q, memWrite_d;
   logic [AW-1:0] memAddr_q, memAddr_d;
   logic [DW-1:0] memWdata_q, memWdata_d;
   logic [DW-1:0] iRdata_q, iRdata_d;
   logic [DW-1:0] dRdata_q, dRdata_d;

   logic          iReq;
   logic          dReq;
   client_e       winner;

   // Pick which client would be granted if the arbiter were idle this cycle.
   always_comb begin
      iReq   = bus.i_read | bus.i_write;
      dReq   = bus.d_read | bus.d_write;
      winner = CLIENT_I;
      if (iReq && dReq) begin
`ifdef MEM_ARB_DPRIO_EN
         winner = CLIENT_D;
`else
         winner = (lastGrant_q == CLIENT_I) ? CLIENT_D : CLIENT_I;
`endif
      end else if (dReq) begin
         winner = CLIENT_D;
      end
   end

   // Next-state logic: latch the winner's request in IDLE, wait for memory
   // in BUSY, and return to IDLE after the single RESP cycle.
   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
`ifndef MEM_ARB_DPRIO_EN
      lastGrant_d = lastGrant_q;
`endif
      memRead_d  = memRead_q;
      memWrite_d = memWrite_q;
      memAddr_d  = memAddr_q;
      memWdata_d = memWdata_q;
      iRdata_d   = iRdata_q;
      dRdata_d   = dRdata_q;

      case (state_q)
         IDLE: begin
            if (iReq || dReq) begin
               state_d = BUSY;
               owner_d = winner;
`ifndef MEM_ARB_DPRIO_EN
               lastGrant_d = winner;
`endif
               // A simultaneous read and write from one client is a write.
               if (winner == CLIENT_D) begin
                  memAddr_d  = bus.d_addr;
                  memWdata_d = bus.d_wdata;
                  memWrite_d = bus.d_write;
                  memRead_d  = bus.d_read & ~bus.d_write;
               end else begin
                  memAddr_d  = bus.i_addr;
                  memWdata_d = bus.i_wdata;
                  memWrite_d = bus.i_write;
                  memRead_d  = bus.i_read & ~bus.i_write;
               end
            end
         end

         BUSY: begin
            if (bus.mem_ready) begin
               memRead_d  = 1'b0;
               memWrite_d = 1'b0;
               state_d    = RESP;
               if (owner_q == CLIENT_D) begin
                  dRdata_d = bus.mem_rdata;
               end else begin
                  iRdata_d = bus.mem_rdata;
               end
            end
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any transaction at once.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q     <= IDLE;
         owner_q     <= CLIENT_I;
`ifndef MEM_ARB_DPRIO_EN
         lastGrant_q <= CLIENT_I;
`endif
         memRead_q   <= 1'b0;
         memWrite_q  <= 1'b0;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         iRdata_q    <= '0;
         dRdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
`ifndef MEM_ARB_DPRIO_EN
         lastGrant_q <= lastGrant_d;
`endif
         memRead_q   <= memRead_d;
         memWrite_q  <= memWrite_d;
         memAddr_q   <= memAddr_d;
         memWdata_q  <= memWdata_d;
         iRdata_q    <= iRdata_d;
         dRdata_q    <= dRdata_d;
      end
   end

   assign bus.mem_read  = memRead_q;
   assign bus.mem_write = memWrite_q;
   assign bus.mem_addr  = memAddr_q;
   assign bus.mem_wdata = memWdata_q;
   assign bus.i_rdata   = iRdata_q;
   assign bus.d_rdata   = dRdata_q;
   assign bus.i_ready   = (state_q == RESP) && (owner_q == CLIENT_I);
   assign bus.d_ready   = (state_q == RESP) && (owner_q == CLIENT_D);

endmodule

// File: tb/tb_mem_arbiter_2to1.sv
// Self-checking bench for mem_arbiter_2to1. A memory model answers strobes
// after memLat cycles; a timestamp-based transaction model predicts every
// arbiter output and a compare process checks them on each falling edge.
// Directed scenarios add hand-computed literal expectations.
module tb_mem_arbiter_2to1;

   localparam int AW = 30;
   localparam int DW = 32;
   localparam int WANT_I   = 0;
   localparam int WANT_D   = 1;
   localparam int WANT_ANY = 2;

   logic clk = 1'b0;
   logic proc_reset_n = 1'b0;

   mem_arbiter_2to1_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter_2to1 #(.AW(AW), .DW(DW)) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .bus          (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Memory environment settings
   int memLat        = 3;
   bit spuriousReady = 1'b0;
   logic [31:0] memArr [logic [29:0]];
   logic [31:0] shadow [logic [29:0]];
   int memCnt = 0;

   function automatic logic [31:0] defaultData(input logic [29:0] a);
      return {a, 2'b01} ^ 32'h1357_9BDF;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   // Memory model: answers the L-th cycle a strobe is seen, stores writes.
   initial forever begin
      @(negedge clk);
      if (!proc_reset_n) begin
         memCnt        = 0;
         bus.mem_ready = 1'b0;
         bus.mem_rdata = 32'h0;
      end else if (bus.mem_read || bus.mem_write) begin
         memCnt++;
         if (memCnt == memLat) begin
            bus.mem_ready = 1'b1;
            if (bus.mem_write) begin
               memArr[bus.mem_addr] = bus.mem_wdata;
               bus.mem_rdata = 32'h0BAD_F00D;
            end else begin
               bus.mem_rdata = memArr.exists(bus.mem_addr) ? memArr[bus.mem_addr]
                                                           : defaultData(bus.mem_addr);
            end
         end else begin
            bus.mem_ready = 1'b0;
         end
      end else begin
         memCnt        = 0;
         bus.mem_ready = spuriousReady;
         if (spuriousReady) bus.mem_rdata = 32'hFFFF_FFFF;
      end
   end

   // Transaction model: a grant at edge g finishes memory at edge g+memLat,
   // presents ready for that one cycle, and the port is free again for
   // arbitration two edges later.
   int          cyc = 0;
   int          doneCyc = 0;
   bit          active = 1'b0;
   bit          ownD = 1'b0;
   bit          isWr = 1'b0;
   bit          lastD = 1'b0;
   bit          mReqI, mReqD, pickD;
   logic [29:0] expAddr = '0;
   logic [31:0] expWdata = '0;
   logic [31:0] expIRdata = '0;
   logic [31:0] expDRdata = '0;
   logic [31:0] modelRet;

   initial forever begin
      @(posedge clk or negedge proc_reset_n);
      if (!proc_reset_n) begin
         active    = 1'b0;
         lastD     = 1'b0;
         isWr      = 1'b0;
         expAddr   = '0;
         expWdata  = '0;
         expIRdata = '0;
         expDRdata = '0;
      end else begin
         cyc++;
         if (active) begin
            if (cyc == doneCyc) begin
               if (isWr) begin
                  shadow[expAddr] = expWdata;
                  modelRet = 32'h0BAD_F00D;
               end else begin
                  modelRet = shadow.exists(expAddr) ? shadow[expAddr] : defaultData(expAddr);
               end
               if (ownD) expDRdata = modelRet;
               else      expIRdata = modelRet;
            end else if (cyc == doneCyc + 1) begin
               active = 1'b0;
            end
         end else begin
            mReqI = bus.i_read | bus.i_write;
            mReqD = bus.d_read | bus.d_write;
            if (mReqI || mReqD) begin
`ifdef MEM_ARB_DPRIO_EN
               pickD = mReqD;
`else
               pickD = mReqD && (!mReqI || !lastD);
`endif
               active   = 1'b1;
               ownD     = pickD;
               lastD    = pickD;
               doneCyc  = cyc + memLat;
               isWr     = pickD ? bus.d_write : bus.i_write;
               expAddr  = pickD ? bus.d_addr  : bus.i_addr;
               expWdata = pickD ? bus.d_wdata : bus.i_wdata;
            end
         end
      end
   end

   // Compare every DUT output against the model once per cycle.
   bit expStrobe;
   initial forever begin
      @(negedge clk);
      expStrobe = active && (cyc < doneCyc);
      checkOutput("cmp_mem_read",  32'(bus.mem_read),  32'(expStrobe && !isWr));
      checkOutput("cmp_mem_write", 32'(bus.mem_write), 32'(expStrobe && isWr));
      checkOutput("cmp_mem_addr",  32'(bus.mem_addr),  32'(expAddr));
      checkOutput("cmp_mem_wdata", bus.mem_wdata, expWdata);
      checkOutput("cmp_i_ready",   32'(bus.i_ready),   32'(active && cyc == doneCyc && !ownD));
      checkOutput("cmp_d_ready",   32'(bus.d_ready),   32'(active && cyc == doneCyc && ownD));
      checkOutput("cmp_i_rdata",   bus.i_rdata, expIRdata);
      checkOutput("cmp_d_rdata",   bus.d_rdata, expDRdata);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic iRd, input logic iWr, input logic [29:0] iA,
                                input logic [31:0] iWd, input logic dRd, input logic dWr,
                                input logic [29:0] dA, input logic [31:0] dWd);
      bus.i_read  = iRd;
      bus.i_write = iWr;
      bus.i_addr  = iA;
      bus.i_wdata = iWd;
      bus.d_read  = dRd;
      bus.d_write = dWr;
      bus.d_addr  = dA;
      bus.d_wdata = dWd;
   endtask

   task automatic waitReady(input int which, input int budget, input string tag,
                            output int edges, output bit gotD);
      bit seen;
      seen  = 1'b0;
      edges = 0;
      gotD  = 1'b0;
      while (!seen && edges < budget) begin
         tick();
         edges++;
         if ((which == WANT_D || which == WANT_ANY) && bus.d_ready) begin
            seen = 1'b1;
            gotD = 1'b1;
         end else if ((which == WANT_I || which == WANT_ANY) && bus.i_ready) begin
            seen = 1'b1;
         end
      end
      checkOutput({tag, "_ready_seen"}, 32'(seen), 32'd1);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   int  edges;
   bit  gotD;
   int  pulses;
   bit  expOrder;

   initial begin
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      memArr[30'h40] = 32'hDEAD_BEEF;  shadow[30'h40] = 32'hDEAD_BEEF;
      memArr[30'h10] = 32'h1010_1010;  shadow[30'h10] = 32'h1010_1010;
      memArr[30'hB0] = 32'h0B0B_0B0B;  shadow[30'hB0] = 32'h0B0B_0B0B;
      proc_reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      proc_reset_n = 1'b1;
      $display("[TB] reset released");
      checkOutput("rst_mem_read", 32'(bus.mem_read), 32'd0);
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
      checkOutput("rst_d_rdata",  bus.d_rdata, 32'd0);
      checkOutput("rst_i_ready",  32'(bus.i_ready), 32'd0);

      // Single D read, memory latency 3
      memLat = 3;
      applyStimulus(0, 0, '0, '0, 1, 0, 30'h40, '0);
      tick();
      checkOutput("t1_mem_read_rise", 32'(bus.mem_read), 32'd1);
      checkOutput("t1_mem_addr", 32'(bus.mem_addr), 32'h40);
      waitReady(WANT_D, 20, "t1", edges, gotD);
      checkOutput("t1_latency_edges", 32'(edges + 1), 32'd4);
      checkOutput("t1_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
      checkOutput("t1_i_ready", 32'(bus.i_ready), 32'd0);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) tick();

      // Single I write, memory latency 2
      memLat = 2;
      applyStimulus(0, 1, 30'h123, 32'hCAFE_0001, 0, 0, '0, '0);
      tick();
      checkOutput("t2_mem_write", 32'(bus.mem_write), 32'd1);
      checkOutput("t2_mem_addr",  32'(bus.mem_addr),  32'h123);
      checkOutput("t2_mem_wdata", bus.mem_wdata, 32'hCAFE_0001);
      waitReady(WANT_I, 20, "t2", edges, gotD);
      checkOutput("t2_latency_edges", 32'(edges + 1), 32'd3);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      checkOutput("t2_mem_stored", memArr[30'h123], 32'hCAFE_0001);
      repeat (2) tick();

      // Simultaneous I read / D write after a fresh reset; address change in BUSY
      proc_reset_n = 1'b0;
      tick();
      proc_reset_n = 1'b1;
      memLat = 2;
      applyStimulus(1, 0, 30'h10, '0, 0, 1, 30'h20, 32'h0000_D020);
      tick();
      checkOutput("t3_first_is_d_write", 32'(bus.mem_write), 32'd1);
      bus.d_addr = 30'h999;
      tick();
      checkOutput("t4_mem_addr_hold", 32'(bus.mem_addr), 32'h20);
      bus.d_addr = 30'h20;
      for (int k = 0; k < 4; k++) begin
         waitReady(WANT_ANY, 20, "t3", edges, gotD);
`ifdef MEM_ARB_DPRIO_EN
         expOrder = 1'b1;
`else
         expOrder = (k % 2) == 0;
`endif
         checkOutput($sformatf("t3_grant%0d_is_d", k), 32'(gotD), 32'(expOrder));
      end
      applyStimulus(1, 0, 30'h10, '0, 0, 0, '0, '0);
      waitReady(WANT_I, 20, "t3_i_after_d_drop", edges, gotD);
      checkOutput("t3_i_rdata", bus.i_rdata, 32'h1010_1010);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) tick();

      // D write-back followed immediately by refill read
      memLat = 2;
      applyStimulus(0, 0, '0, '0, 0, 1, 30'hA0, 32'h1111_00A0);
      waitReady(WANT_D, 20, "t5_wb", edges, gotD);
      checkOutput("t5_wb_rdata", bus.d_rdata, 32'h0BAD_F00D);
      applyStimulus(0, 0, '0, '0, 1, 0, 30'hB0, '0);
      tick();
      checkOutput("t5_idle_no_write", 32'(bus.mem_write), 32'd0);
      tick();
      checkOutput("t5_refill_read", 32'(bus.mem_read), 32'd1);
      checkOutput("t5_refill_addr", 32'(bus.mem_addr), 32'hB0);
      waitReady(WANT_D, 20, "t5_refill", edges, gotD);
      checkOutput("t5_refill_rdata", bus.d_rdata, 32'h0B0B_0B0B);
      checkOutput("t5_wb_stored", memArr[30'hA0], 32'h1111_00A0);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) tick();

      // Reset in the middle of a BUSY transaction
      memLat = 4;
      applyStimulus(0, 0, '0, '0, 1, 0, 30'h40, '0);
      tick();
      tick();
      proc_reset_n = 1'b0;
      #1;
      checkOutput("t6_mem_read_drop", 32'(bus.mem_read), 32'd0);
      checkOutput("t6_d_rdata_clear", bus.d_rdata, 32'd0);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      @(posedge clk);
      #1;
      proc_reset_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (bus.i_ready || bus.d_ready) pulses++;
      end
      checkOutput("t6_no_ready", 32'(pulses), 32'd0);
      memLat = 1;
      applyStimulus(1, 0, 30'h10, '0, 0, 0, '0, '0);
      waitReady(WANT_I, 20, "t6_after", edges, gotD);
      checkOutput("t6_i_rdata", bus.i_rdata, 32'h1010_1010);
      applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
      repeat (2) tick();

      // mem_ready while idle must be ignored
      spuriousReady = 1'b1;
      pulses = 0;
      repeat (2) begin
         tick();
         if (bus.i_ready || bus.d_ready) pulses++;
      end
      spuriousReady = 1'b0;
      repeat (2) begin
         tick();
         if (bus.i_ready || bus.d_ready) pulses++;
      end
      checkOutput("t7_spurious_ignored", 32'(pulses), 32'd0);
      checkOutput("t7_i_rdata_kept", bus.i_rdata, 32'h1010_1010);

      repeat (2) tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
